// File: rtl/input_buffer_ctrl.sv
// input_buffer_ctrl
//   Drives an external serial-in/parallel-out shift-register chain
//   (74HC595 style) from a parallel SRAM word.
//   A clear request pulses the chain master reset and then latches
//   the zeroed chain.
//   A load request shifts the captured word in MSB first and then
//   latches it.
//
// Parameters
//   WIDTH           chain length in bits (2..1024)
//
// Ports
//   CLK             system clock, rising edge
//   RST             asynchronous active-high reset
//   CLEAR_BUFFER    request: zero the chain storage registers
//   LOAD_SRAM_DATA  request: shift SRAM_DATA into the chain and latch it
//   SRAM_DATA       parallel word to transfer (captured on acceptance)
//   READY           high only when idle; requests are sampled only then
//   DS              serial data to the first chain stage
//   MR_BAR          active-low chain master reset
//   SHCP            chain shift clock
//   STCP            chain storage (latch) clock
//   OE_BAR          active-low chain output enable
//
// Configuration
//   INPUT_BUFFER_OE_CTRL_EN  when defined, OE_BAR stays high after reset
//                            until the first latch pulse has completed.
//                            When undefined, OE_BAR simply follows RST.

module input_buffer_ctrl #(
    parameter int WIDTH = 128
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             CLEAR_BUFFER,
    input  logic             LOAD_SRAM_DATA,
    input  logic [WIDTH-1:0] SRAM_DATA,
    output logic             READY,
    output logic             DS,
    output logic             MR_BAR,
    output logic             SHCP,
    output logic             STCP,
    output logic             OE_BAR
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        CLR_LATCH,
        SHIFT_LO,
        SHIFT_HI,
        LATCH
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shadow;

    // Every output is assigned together with the next state, so each one
    // already holds the value that belongs to the state being entered.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= '0;
            shadow <= '0;
            READY  <= 1'b1;
            DS     <= 1'b0;
            MR_BAR <= 1'b1;
            SHCP   <= 1'b0;
            STCP   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (CLEAR_BUFFER) begin
                        state  <= CLR;
                        cnt    <= '0;
                        READY  <= 1'b0;
                        MR_BAR <= 1'b0;
                    end else if (LOAD_SRAM_DATA) begin
                        state  <= SHIFT_LO;
                        cnt    <= '0;
                        shadow <= SRAM_DATA;
                        DS     <= SRAM_DATA[WIDTH-1];
                        READY  <= 1'b0;
                    end
                end
                CLR: begin
                    // cnt distinguishes the first and second reset cycles.
                    if (cnt == '0) begin
                        cnt <= CNT_W'(1);
                    end else begin
                        state  <= CLR_LATCH;
                        MR_BAR <= 1'b1;
                        STCP   <= 1'b1;
                    end
                end
                CLR_LATCH: begin
                    state <= IDLE;
                    STCP  <= 1'b0;
                    READY <= 1'b1;
                end
                SHIFT_LO: begin
                    state <= SHIFT_HI;
                    SHCP  <= 1'b1;
                end
                SHIFT_HI: begin
                    SHCP <= 1'b0;
                    if (cnt == LAST_BIT) begin
                        state <= LATCH;
                        STCP  <= 1'b1;
                    end else begin
                        // The shadow rotates left, so bit WIDTH-2 always
                        // holds the next bit to present on DS.
                        state  <= SHIFT_LO;
                        cnt    <= cnt + CNT_W'(1);
                        DS     <= shadow[WIDTH-2];
                        shadow <= {shadow[WIDTH-2:0], shadow[WIDTH-1]};
                    end
                end
                LATCH: begin
                    state <= IDLE;
                    STCP  <= 1'b0;
                    READY <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    READY <= 1'b1;
                    SHCP  <= 1'b0;
                    STCP  <= 1'b0;
                end
            endcase
        end
    end

`ifdef INPUT_BUFFER_OE_CTRL_EN
    // Outputs remain disabled until a complete latch has put known data
    // into the chain storage registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            OE_BAR <= 1'b1;
        end else if (state == LATCH || state == CLR_LATCH) begin
            OE_BAR <= 1'b0;
        end
    end
`else
    assign OE_BAR = RST;
`endif

endmodule
